// File: rtl/tawas_imem_arb.sv
// Instruction-memory port arbiter: the fetch unit owns the single-port RAM in run mode,
// the host steals rate-limited cycles, and owns the RAM outright while loading a program.
module tawas_imem_arb #(
   parameter int unsigned STEAL_GAP = 4
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        LOAD_MODE,
   input  logic [23:0] IADDR,
   output logic [31:0] IDATA,
   output logic        FETCH_HOLD,
   output logic        CORE_RST,
   input  logic        HOST_REQ,
   input  logic        HOST_WE,
   input  logic [23:0] HOST_ADDR,
   input  logic [31:0] HOST_WDATA,
   output logic        HOST_ACK,
   output logic [31:0] HOST_RDATA,
   output logic        RAM_CE,
   output logic        RAM_WE,
   output logic [23:0] RAM_ADDR,
   output logic [31:0] RAM_WDATA,
   input  logic [31:0] RAM_RDATA
);

   typedef enum logic [1:0] {
      ST_RUN       = 2'd0,
      ST_STEAL     = 2'd1,
      ST_LOAD      = 2'd2,
      ST_LOAD_EXIT = 2'd3
   } state_t;

   localparam logic [3:0] GAP_RELOAD = 4'(STEAL_GAP);

   state_t      state_r;
   state_t      next_state_s;
   logic [3:0]  gap_r;
   logic [1:0]  exit_cnt_r;
   logic        core_rst_r;
   logic        host_ack_r;
   logic        host_ack_s;
   logic        grant_s;
   logic        steal_s;
   logic        fetch_cycle_s;
   logic        exit_run_s;
   logic        ram_ce_s;
   logic        ram_we_s;
   logic [23:0] ram_addr_s;

   // An access in flight is dropped the moment reset is seen, so its ACK never reaches the host.
   assign host_ack_s = host_ack_r & ~RST;

   assign IDATA      = RAM_RDATA;
   assign HOST_RDATA = RAM_RDATA;
   assign HOST_ACK   = host_ack_s;
   assign CORE_RST   = core_rst_r;
   assign FETCH_HOLD = (state_r == ST_STEAL) & ~RST;
   assign RAM_CE     = ram_ce_s;
   assign RAM_WE     = ram_we_s;
   assign RAM_ADDR   = ram_addr_s;
   assign RAM_WDATA  = HOST_WDATA;

   // Next-state decode and RAM port steering between fetch and host.
   always_comb begin
      next_state_s  = state_r;
      grant_s       = 1'b0;
      steal_s       = 1'b0;
      fetch_cycle_s = 1'b0;
      exit_run_s    = 1'b0;
      ram_ce_s      = 1'b0;
      ram_addr_s    = IADDR;
      case (state_r)
         ST_RUN: begin
            ram_ce_s = 1'b1;
            if (HOST_REQ && (gap_r == 4'd0) && !host_ack_s && !RST) begin
               grant_s      = 1'b1;
               steal_s      = 1'b1;
               next_state_s = ST_STEAL;
            end else begin
               fetch_cycle_s = 1'b1;
               next_state_s  = LOAD_MODE ? ST_LOAD : ST_RUN;
            end
         end
         ST_STEAL: begin
            ram_ce_s      = 1'b1;
            fetch_cycle_s = 1'b1;
            next_state_s  = LOAD_MODE ? ST_LOAD : ST_RUN;
         end
         ST_LOAD: begin
            // Any outstanding ACK completes in this cycle, so leaving needs no extra wait.
            if (!LOAD_MODE) begin
               next_state_s = ST_LOAD_EXIT;
            end else if (HOST_REQ && !host_ack_s && !RST) begin
               grant_s      = 1'b1;
               ram_ce_s     = 1'b1;
               next_state_s = ST_LOAD;
            end else begin
               next_state_s = ST_LOAD;
            end
         end
         ST_LOAD_EXIT: begin
            if (LOAD_MODE) begin
               next_state_s = ST_LOAD;
            end else if (exit_cnt_r == 2'd2) begin
               exit_run_s   = 1'b1;
               next_state_s = ST_RUN;
            end else begin
               next_state_s = ST_LOAD_EXIT;
            end
         end
         default: begin
            next_state_s = ST_LOAD_EXIT;
         end
      endcase
      if (grant_s) begin
         ram_addr_s = HOST_ADDR;
      end else begin
         ram_addr_s = IADDR;
      end
      ram_we_s = grant_s & HOST_WE;
   end

   // State, steal-gap, core-reset and exit-counter registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r    <= LOAD_MODE ? ST_LOAD : ST_LOAD_EXIT;
         core_rst_r <= 1'b1;
         host_ack_r <= 1'b0;
         gap_r      <= GAP_RELOAD;
         exit_cnt_r <= 2'd0;
      end else begin
         state_r    <= next_state_s;
         host_ack_r <= grant_s;
         if (steal_s || exit_run_s) begin
            gap_r <= GAP_RELOAD;
         end else if (fetch_cycle_s && (gap_r != 4'd0)) begin
            gap_r <= gap_r - 4'd1;
         end
         if (next_state_s == ST_LOAD) begin
            core_rst_r <= 1'b1;
         end else if (exit_run_s) begin
            core_rst_r <= 1'b0;
         end
         if ((state_r == ST_LOAD_EXIT) && (next_state_s == ST_LOAD_EXIT)) begin
            exit_cnt_r <= exit_cnt_r + 2'd1;
         end else begin
            exit_cnt_r <= 2'd0;
         end
      end
   end

endmodule

// File: tb/tb_tawas_imem_arb.sv
// Bench for tawas_imem_arb: behavioural RAM, host-ACK scoreboard, one task per scenario.
module tb_tawas_imem_arb;

   localparam int unsigned GAP = 4;

   logic        CLK = 1'b0;
   logic        RST;
   logic        LOAD_MODE;
   logic [23:0] IADDR;
   logic [31:0] IDATA;
   logic        FETCH_HOLD;
   logic        CORE_RST;
   logic        HOST_REQ;
   logic        HOST_WE;
   logic [23:0] HOST_ADDR;
   logic [31:0] HOST_WDATA;
   logic        HOST_ACK;
   logic [31:0] HOST_RDATA;
   logic        RAM_CE;
   logic        RAM_WE;
   logic [23:0] RAM_ADDR;
   logic [31:0] RAM_WDATA;
   logic [31:0] RAM_RDATA;

   typedef struct {
      logic        we;
      logic [31:0] data;
      logic        hold;
   } exp_t;

   exp_t        exp_q[$];
   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   logic        mem_init = 1'b1;
   logic [31:0] mem [0:255];

   tawas_imem_arb #(.STEAL_GAP(GAP)) dut (
      .CLK(CLK), .RST(RST), .LOAD_MODE(LOAD_MODE), .IADDR(IADDR), .IDATA(IDATA),
      .FETCH_HOLD(FETCH_HOLD), .CORE_RST(CORE_RST), .HOST_REQ(HOST_REQ), .HOST_WE(HOST_WE),
      .HOST_ADDR(HOST_ADDR), .HOST_WDATA(HOST_WDATA), .HOST_ACK(HOST_ACK),
      .HOST_RDATA(HOST_RDATA), .RAM_CE(RAM_CE), .RAM_WE(RAM_WE), .RAM_ADDR(RAM_ADDR),
      .RAM_WDATA(RAM_WDATA), .RAM_RDATA(RAM_RDATA)
   );

   initial forever #5 CLK = ~CLK;

   initial forever begin
      @(posedge CLK);
      cyc++;
   end

   // Fetch address keeps moving so RAM_ADDR can be told apart from host addresses.
   initial begin
      IADDR = 24'h800000;
      forever begin
         @(posedge CLK);
         #1;
         IADDR = 24'h800000 + 24'(cyc & 255);
      end
   end

   // Synchronous single-port RAM, one-cycle read latency.
   always @(posedge CLK) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | 32'(i);
         mem[16] <= 32'hDEAD_BEEF;
      end else if (RAM_CE) begin
         if (RAM_WE) mem[RAM_ADDR[7:0]] <= RAM_WDATA;
         RAM_RDATA <= mem[RAM_ADDR[7:0]];
      end
   end

   // Scoreboard: every HOST_ACK must match the oldest expected access.
   always @(negedge CLK) begin
      if (HOST_ACK === 1'b1) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_ack cyc=%0d got ack=1 want none", cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if ((!e.we && HOST_RDATA !== e.data) || FETCH_HOLD !== e.hold) begin
               bad++;
               $display("FAIL ack_data cyc=%0d got rdata=%h hold=%b want rdata=%h hold=%b",
                        cyc, HOST_RDATA, FETCH_HOLD, e.data, e.hold);
            end
         end
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic core_rst_release(input string name);
      for (int k = 0; k < 4; k++) begin
         @(negedge CLK);
         total++;
         if (CORE_RST !== (k < 3) || FETCH_HOLD !== 1'b0 || RAM_ADDR !== IADDR) begin
            bad++;
            $display("FAIL %s k=%0d got core_rst=%b hold=%b addr=%h want core_rst=%b hold=0 addr=%h",
                     name, k, CORE_RST, FETCH_HOLD, RAM_ADDR, (k < 3), IADDR);
         end
      end
      step();
   endtask

   task automatic test_reset();
      RST = 1'b1; LOAD_MODE = 1'b0; HOST_REQ = 1'b0; HOST_WE = 1'b0;
      HOST_ADDR = 24'h0; HOST_WDATA = 32'h0;
      repeat (3) step();
      @(negedge CLK);
      total++;
      if ({CORE_RST, HOST_ACK, FETCH_HOLD} !== 3'b100) begin
         bad++;
         $display("FAIL reset_state got rst/ack/hold=%b want 100", {CORE_RST, HOST_ACK, FETCH_HOLD});
      end
      step();
      RST = 1'b0;
      mem_init = 1'b0;
      core_rst_release("reset_release");
   endtask

   task automatic test_steal_read();
      repeat (6) step();
      HOST_ADDR = 24'h000010; HOST_WE = 1'b0; HOST_REQ = 1'b1;
      exp_q.push_back('{1'b0, 32'hDEAD_BEEF, 1'b1});
      @(negedge CLK);
      total++;
      if ({RAM_ADDR, RAM_WE, RAM_CE, FETCH_HOLD} !== {24'h000010, 3'b010}) begin
         bad++;
         $display("FAIL steal_grant got addr=%h we=%b ce=%b hold=%b want addr=000010 we=0 ce=1 hold=0",
                  RAM_ADDR, RAM_WE, RAM_CE, FETCH_HOLD);
      end
      @(negedge CLK);
      total++;
      if ({HOST_ACK, FETCH_HOLD} !== 2'b11 || RAM_ADDR !== IADDR) begin
         bad++;
         $display("FAIL steal_ack got ack=%b hold=%b addr=%h want ack=1 hold=1 addr=%h",
                  HOST_ACK, FETCH_HOLD, RAM_ADDR, IADDR);
      end
      HOST_REQ = 1'b0;
      step();
   endtask

   task automatic test_back_to_back();
      int g[3];
      int k     = 0;
      int holds = 0;
      repeat (6) step();
      for (int i = 0; i < 3; i++) exp_q.push_back('{1'b0, 32'hA500_0020 + 32'(i), 1'b1});
      HOST_ADDR = 24'h000020; HOST_WE = 1'b0; HOST_REQ = 1'b1;
      for (int c = 0; c < 40 && k < 3; c++) begin
         @(negedge CLK);
         holds += int'(FETCH_HOLD);
         if (HOST_ACK === 1'b1) begin
            g[k] = cyc - 1;
            k++;
            if (k < 3) HOST_ADDR = 24'h000020 + 24'(k);
            else HOST_REQ = 1'b0;
         end
      end
      HOST_REQ = 1'b0;
      total++;
      if (k != 3) begin
         bad++;
         $display("FAIL b2b_count got acks=%0d want 3", k);
         exp_q.delete();
      end else begin
         for (int i = 0; i < 2; i++) begin
            total++;
            if (g[i+1] - g[i] != int'(GAP) + 1) begin
               bad++;
               $display("FAIL b2b_spacing i=%0d got %0d want %0d", i, g[i+1] - g[i], GAP + 1);
            end
         end
         total++;
         if (holds != 3) begin
            bad++;
            $display("FAIL b2b_holds got %0d want 3", holds);
         end
      end
      step();
   endtask

   task automatic test_load();
      int   g[4];
      logic we_g[4];
      int   k      = 0;
      logic prv_we = 1'b0;
      logic cr_ok  = 1'b1;
      step();
      LOAD_MODE = 1'b1;
      step(); step();
      @(negedge CLK);
      total++;
      if ({CORE_RST, RAM_CE, FETCH_HOLD} !== 3'b100) begin
         bad++;
         $display("FAIL load_idle got rst/ce/hold=%b want 100", {CORE_RST, RAM_CE, FETCH_HOLD});
      end
      step();
      for (int i = 0; i < 4; i++) exp_q.push_back('{1'b1, 32'h0, 1'b0});
      HOST_ADDR = 24'h0; HOST_WDATA = 32'h1111_0000; HOST_WE = 1'b1; HOST_REQ = 1'b1;
      for (int c = 0; c < 40 && k < 4; c++) begin
         @(negedge CLK);
         if (CORE_RST !== 1'b1) cr_ok = 1'b0;
         if (HOST_ACK === 1'b1) begin
            g[k] = cyc - 1;
            we_g[k] = prv_we;
            k++;
            if (k < 4) begin
               HOST_ADDR  = 24'(k);
               HOST_WDATA = 32'h1111_0000 + 32'(k);
            end else begin
               HOST_REQ = 1'b0;
            end
         end
         prv_we = RAM_WE;
      end
      HOST_REQ = 1'b0; HOST_WE = 1'b0;
      total++;
      if (k != 4 || !cr_ok) begin
         bad++;
         $display("FAIL load_writes got acks=%0d core_rst_held=%b want 4 1", k, cr_ok);
         exp_q.delete();
      end else begin
         for (int i = 0; i < 3; i++) begin
            total++;
            if (g[i+1] - g[i] != 2 || we_g[i] !== 1'b1) begin
               bad++;
               $display("FAIL load_spacing i=%0d got gap=%0d we=%b want 2 1", i, g[i+1] - g[i], we_g[i]);
            end
         end
      end
      step();
      for (int i = 0; i < 4; i++) begin
         total++;
         if (mem[i] !== 32'h1111_0000 + 32'(i)) begin
            bad++;
            $display("FAIL load_mem a=%0d got %h want %h", i, mem[i], 32'h1111_0000 + 32'(i));
         end
      end
      LOAD_MODE = 1'b0;
      for (int j = 0; j < 5; j++) begin
         @(negedge CLK);
         total++;
         if (CORE_RST !== (j < 4)) begin
            bad++;
            $display("FAIL load_exit j=%0d got core_rst=%b want %b", j, CORE_RST, (j < 4));
         end
      end
      step();
   endtask

   task automatic test_load_race();
      repeat (6) step();
      HOST_ADDR = 24'h000002; HOST_WE = 1'b0; HOST_REQ = 1'b1; LOAD_MODE = 1'b1;
      exp_q.push_back('{1'b0, 32'h1111_0002, 1'b1});
      @(negedge CLK);
      total++;
      if ({RAM_ADDR, RAM_WE, RAM_CE} !== {24'h000002, 2'b01}) begin
         bad++;
         $display("FAIL race_grant got addr=%h we=%b ce=%b want 000002 0 1", RAM_ADDR, RAM_WE, RAM_CE);
      end
      @(negedge CLK);
      total++;
      if ({HOST_ACK, FETCH_HOLD} !== 2'b11) begin
         bad++;
         $display("FAIL race_ack got ack=%b hold=%b want 1 1", HOST_ACK, FETCH_HOLD);
      end
      HOST_REQ = 1'b0;
      @(negedge CLK);
      total++;
      if ({CORE_RST, FETCH_HOLD, RAM_CE} !== 3'b100) begin
         bad++;
         $display("FAIL race_load got rst/hold/ce=%b want 100", {CORE_RST, FETCH_HOLD, RAM_CE});
      end
      step();
      LOAD_MODE = 1'b0;
      repeat (6) step();
   endtask

   task automatic test_rst_steal();
      repeat (6) step();
      HOST_ADDR = 24'h000030; HOST_WE = 1'b0; HOST_REQ = 1'b1;
      @(negedge CLK);
      total++;
      if ({RAM_ADDR, RAM_CE} !== {24'h000030, 1'b1}) begin
         bad++;
         $display("FAIL rst_grant got addr=%h ce=%b want 000030 1", RAM_ADDR, RAM_CE);
      end
      step();
      RST = 1'b1;
      @(negedge CLK);
      total++;
      if ({HOST_ACK, FETCH_HOLD} !== 2'b00) begin
         bad++;
         $display("FAIL rst_steal got ack=%b hold=%b want 0 0", HOST_ACK, FETCH_HOLD);
      end
      HOST_REQ = 1'b0;
      step();
      RST = 1'b0;
      core_rst_release("rst_steal_release");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d got timeout want finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_steal_read();
      test_back_to_back();
      test_load();
      test_load_race();
      test_rst_steal();
      repeat (3) step();
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL leftover_expect got %0d want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
